// File: rtl/ring_lock_ctrl.sv
// Ring resonance lock: coarse heater sweep to find the optical power peak, then a +/-1 LSB hill-climb.
// Every code change waits SETTLE_CYCLES before 2^LOG2_SAMPLES valid samples are summed; pwr_valid stalls MEASURE indefinitely.
module ring_lock_ctrl #(
    parameter int CODE_WIDTH    = 8,
    parameter int SAMPLE_WIDTH  = 8,
    parameter int LOG2_SAMPLES  = 3,
    parameter int SETTLE_CYCLES = 16,
    parameter int SWEEP_STEP    = 16,
    parameter int LOCK_FLIPS    = 4,
    parameter int CODE_INIT     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    pwr_valid,
    input  logic [SAMPLE_WIDTH-1:0] pwr_sample,
    output logic [CODE_WIDTH-1:0]   heater_code,
    output logic                    heater_pdm,
    output logic                    tracking,
    output logic                    locked
);

    localparam int SUM_W  = SAMPLE_WIDTH + LOG2_SAMPLES;
    localparam int NCNT_W = LOG2_SAMPLES + 1;
    localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int FLIP_W = $clog2(LOCK_FLIPS + 1);

    localparam logic [CODE_WIDTH-1:0] CODE_MAX    = '1;
    localparam logic [31:0]           CODE_MAX_W  = 32'(CODE_MAX);
    localparam logic [NCNT_W-1:0]     LAST_SAMPLE = NCNT_W'((1 << LOG2_SAMPLES) - 1);
    localparam logic [SCNT_W-1:0]     LAST_SETTLE = SCNT_W'(SETTLE_CYCLES - 1);
    localparam logic [FLIP_W-1:0]     FLIP_SAT    = FLIP_W'(LOCK_FLIPS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DECIDE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SCNT_W-1:0]     settle_cnt;
    logic [NCNT_W-1:0]     sample_cnt;
    logic [SUM_W-1:0]      sum;
    logic [SUM_W-1:0]      best_sum;
    logic [SUM_W-1:0]      prev_sum;
    logic [CODE_WIDTH-1:0] best_code;
    logic [CODE_WIDTH-1:0] pdm_acc;
    logic                  phase_track;
    logic                  first;
    logic                  dir_up;
    logic [FLIP_W-1:0]     flips;

    logic start;
    logic settle_done;
    logic take_sample;
    logic last_sample;
    logic decide;

    logic                  sweep_better;
    logic                  sweep_done;
    logic [31:0]           sweep_reach;
    logic [CODE_WIDTH-1:0] sweep_best_code;

    logic                  trk_dir;
    logic                  trk_rev;
    logic                  trk_at_edge;
    logic                  trk_locked;
    logic [FLIP_W-1:0]     trk_flips;
    logic [CODE_WIDTH-1:0] trk_code;

    function automatic logic [FLIP_W-1:0] flip_inc(input logic [FLIP_W-1:0] f);
        return (f >= FLIP_SAT) ? FLIP_SAT : f + FLIP_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = SETTLE;
                SETTLE:  if (settle_done) state_nxt = MEASURE;
                MEASURE: if (last_sample) state_nxt = DECIDE;
                DECIDE:  state_nxt = SETTLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start       = 1'b0;
        settle_done = 1'b0;
        take_sample = 1'b0;
        last_sample = 1'b0;
        decide      = 1'b0;
        case (state)
            IDLE:    start = enable;
            SETTLE:  settle_done = (settle_cnt == LAST_SETTLE);
            MEASURE: begin
                take_sample = enable && pwr_valid;
                last_sample = take_sample && (sample_cnt == LAST_SAMPLE);
            end
            DECIDE:  decide = enable;
            default: ;
        endcase
    end

    // The last sweep point may itself be the best, so the hand-off uses the freshly compared code.
    always_comb begin
        sweep_better    = (sum > best_sum);
        sweep_best_code = sweep_better ? heater_code : best_code;
        sweep_reach     = 32'(heater_code) + 32'(SWEEP_STEP);
        sweep_done      = (sweep_reach > CODE_MAX_W);
    end

    always_comb begin
        trk_dir   = dir_up;
        trk_flips = flips;
        trk_rev   = 1'b0;
        if (!first) begin
            if (sum >= prev_sum) begin
                trk_flips = '0;
            end else begin
                trk_dir   = ~dir_up;
                trk_flips = flip_inc(flips);
                trk_rev   = 1'b1;
            end
        end
        // Bouncing off either end of the code range is treated as a reversal.
        trk_at_edge = trk_dir ? (heater_code == CODE_MAX) : (heater_code == '0);
        if (trk_at_edge) begin
            trk_dir   = ~trk_dir;
            trk_flips = flip_inc(trk_flips);
            trk_rev   = 1'b1;
        end
        trk_code   = trk_dir ? heater_code + CODE_WIDTH'(1) : heater_code - CODE_WIDTH'(1);
        trk_locked = trk_rev ? (trk_flips >= FLIP_SAT) : (first ? locked : 1'b0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pdm_acc    <= '0;
            heater_pdm <= 1'b0;
        end else begin
            {heater_pdm, pdm_acc} <= {1'b0, pdm_acc} + {1'b0, heater_code};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            settle_cnt <= '0;
        end else if (state == SETTLE && enable && !settle_done) begin
            settle_cnt <= settle_cnt + SCNT_W'(1);
        end else begin
            settle_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum        <= '0;
            sample_cnt <= '0;
        end else if (!enable || decide || state == IDLE) begin
            sum        <= '0;
            sample_cnt <= '0;
        end else if (take_sample) begin
            sum        <= sum + SUM_W'(pwr_sample);
            sample_cnt <= last_sample ? '0 : sample_cnt + NCNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            heater_code <= CODE_WIDTH'(CODE_INIT);
            best_sum    <= '0;
            best_code   <= '0;
            prev_sum    <= '0;
            phase_track <= 1'b0;
            first       <= 1'b0;
            dir_up      <= 1'b1;
            flips       <= '0;
            tracking    <= 1'b0;
            locked      <= 1'b0;
        end else if (!enable) begin
            tracking <= 1'b0;
            locked   <= 1'b0;
        end else if (start) begin
            heater_code <= '0;
            best_sum    <= '0;
            best_code   <= '0;
            phase_track <= 1'b0;
        end else if (decide && !phase_track) begin
            if (sweep_better) begin
                best_sum  <= sum;
                best_code <= heater_code;
            end
            if (sweep_done) begin
                heater_code <= sweep_best_code;
                phase_track <= 1'b1;
                tracking    <= 1'b1;
                first       <= 1'b1;
                dir_up      <= 1'b1;
                flips       <= '0;
            end else begin
                heater_code <= heater_code + CODE_WIDTH'(SWEEP_STEP);
            end
        end else if (decide) begin
            heater_code <= trk_code;
            dir_up      <= trk_dir;
            flips       <= trk_flips;
            prev_sum    <= sum;
            first       <= 1'b0;
            locked      <= trk_locked;
        end
    end

endmodule
